noc_tag_generator: RTL

- Parametrised successor to the fixed-function filter tag counter in the Network on Chip controller.
- Walks a 3-level loop nest (outer row index, middle set index, inner channel index) over run-time dimensions, for a programmable number of passes.
- Emits row/col multicast tags with a valid/ready handshake, a programmable column stride and row/col offsets, and done/busy status.
- One instance per data type (filter, ifmap, psum) in the NoC controller.

---
 rtl/noc_tag_generator.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/noc_tag_generator.sv
// 3-level loop-nest row/col multicast tag generator with valid/ready handshake.
// Optional tag_last/tag_pass outputs are enabled by defining NOC_TAG_LAST_EN.
module noc_tag_generator #(
    parameter int OUT_WIDTH     = 4,
    parameter int MID_WIDTH     = 2,
    parameter int IN_WIDTH      = 3,
    parameter int PASS_WIDTH    = 8,
    parameter int STRIDE_WIDTH  = 4,
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [OUT_WIDTH-1:0]     cfg_out,
    input  logic [MID_WIDTH-1:0]     cfg_mid,
    input  logic [IN_WIDTH-1:0]      cfg_in,
    input  logic [PASS_WIDTH-1:0]    cfg_passes,
    input  logic [STRIDE_WIDTH-1:0]  cfg_col_stride,
    input  logic [ROW_TAG_WIDTH-1:0] cfg_row_offset,
    input  logic [COL_TAG_WIDTH-1:0] cfg_col_offset,
    output logic                     tag_valid,
    input  logic                     tag_ready,
    output logic [ROW_TAG_WIDTH-1:0] row_tag,
    output logic [COL_TAG_WIDTH-1:0] col_tag,
    output logic                     busy,
    output logic                     done
`ifdef NOC_TAG_LAST_EN
    ,
    output logic                     tag_last,
    output logic [PASS_WIDTH-1:0]    tag_pass
`endif
);

    localparam int PW = MID_WIDTH + STRIDE_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [OUT_WIDTH-1:0]     out_idx_q, out_idx_d, out_max_q, out_max_d;
    logic [MID_WIDTH-1:0]     mid_idx_q, mid_idx_d, mid_max_q, mid_max_d;
    logic [IN_WIDTH-1:0]      in_idx_q, in_idx_d, in_max_q, in_max_d;
    logic [PASS_WIDTH-1:0]    pass_idx_q, pass_idx_d, pass_max_q, pass_max_d;
    logic [STRIDE_WIDTH-1:0]  stride_q, stride_d;
    logic [ROW_TAG_WIDTH-1:0] row_off_q, row_off_d;
    logic [COL_TAG_WIDTH-1:0] col_off_q, col_off_d;
    logic                     valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    logic                     fire;
    logic                     in_last, mid_last, out_last, pass_last;

    assign fire      = valid_q && tag_ready;
    assign in_last   = (in_idx_q == in_max_q);
    assign mid_last  = (mid_idx_q == mid_max_q);
    assign out_last  = (out_idx_q == out_max_q);
    assign pass_last = (pass_idx_q == pass_max_q);

    always_comb begin
        state_d    = state_q;
        out_idx_d  = out_idx_q;
        mid_idx_d  = mid_idx_q;
        in_idx_d   = in_idx_q;
        pass_idx_d = pass_idx_q;
        out_max_d  = out_max_q;
        mid_max_d  = mid_max_q;
        in_max_d   = in_max_q;
        pass_max_d = pass_max_q;
        stride_d   = stride_q;
        row_off_d  = row_off_q;
        col_off_d  = col_off_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Extents are stored as max index so a zero extent collapses to one iteration.
                    out_max_d  = (cfg_out    == '0) ? '0 : cfg_out    - OUT_WIDTH'(1);
                    mid_max_d  = (cfg_mid    == '0) ? '0 : cfg_mid    - MID_WIDTH'(1);
                    in_max_d   = (cfg_in     == '0) ? '0 : cfg_in     - IN_WIDTH'(1);
                    pass_max_d = (cfg_passes == '0) ? '0 : cfg_passes - PASS_WIDTH'(1);
                    stride_d   = cfg_col_stride;
                    row_off_d  = cfg_row_offset;
                    col_off_d  = cfg_col_offset;
                    out_idx_d  = '0;
                    mid_idx_d  = '0;
                    in_idx_d   = '0;
                    pass_idx_d = '0;
                    state_d    = S_RUN;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                if (fire) begin
                    if (!in_last) begin
                        in_idx_d = in_idx_q + IN_WIDTH'(1);
                    end else begin
                        in_idx_d = '0;
                        if (!mid_last) begin
                            mid_idx_d = mid_idx_q + MID_WIDTH'(1);
                        end else begin
                            mid_idx_d = '0;
                            if (!out_last) begin
                                out_idx_d = out_idx_q + OUT_WIDTH'(1);
                            end else begin
                                out_idx_d = '0;
                                if (pass_last) begin
                                    pass_idx_d = '0;
                                    state_d    = S_DONE;
                                    valid_d    = 1'b0;
                                    done_d     = 1'b1;
                                end else begin
                                    pass_idx_d = pass_idx_q + PASS_WIDTH'(1);
                                end
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            out_idx_d  = '0;
            mid_idx_d  = '0;
            in_idx_d   = '0;
            pass_idx_d = '0;
            valid_d    = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            out_idx_q  <= '0;
            mid_idx_q  <= '0;
            in_idx_q   <= '0;
            pass_idx_q <= '0;
            out_max_q  <= '0;
            mid_max_q  <= '0;
            in_max_q   <= '0;
            pass_max_q <= '0;
            stride_q   <= '0;
            row_off_q  <= '0;
            col_off_q  <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_idx_q  <= out_idx_d;
            mid_idx_q  <= mid_idx_d;
            in_idx_q   <= in_idx_d;
            pass_idx_q <= pass_idx_d;
            out_max_q  <= out_max_d;
            mid_max_q  <= mid_max_d;
            in_max_q   <= in_max_d;
            pass_max_q <= pass_max_d;
            stride_q   <= stride_d;
            row_off_q  <= row_off_d;
            col_off_q  <= col_off_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Outside RUN the counters are zero, so tags reflect the live offsets.
    logic [ROW_TAG_WIDTH-1:0] row_off_sel;
    logic [COL_TAG_WIDTH-1:0] col_off_sel;
    logic [PW-1:0]            mid_term;

    assign row_off_sel = (state_q == S_RUN) ? row_off_q : cfg_row_offset;
    assign col_off_sel = (state_q == S_RUN) ? col_off_q : cfg_col_offset;
    assign mid_term    = PW'(mid_idx_q) * PW'(stride_q);

    assign row_tag   = ROW_TAG_WIDTH'(out_idx_q) + row_off_sel;
    assign col_tag   = COL_TAG_WIDTH'(in_idx_q) + COL_TAG_WIDTH'(mid_term) + col_off_sel;
    assign tag_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef NOC_TAG_LAST_EN
    assign tag_last = valid_q && in_last && mid_last && out_last;
    assign tag_pass = valid_q ? pass_idx_q : '0;
`endif

endmodule
